// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one UART transmitter
// between N_REQ byte requesters in the tx_clk domain.
// Optional feature macro: UART_TX_ARB_TIMEOUT_EN. When defined, WAIT_BUSY
// aborts after TIMEOUT cycles without tx_busy and sets a sticky err_timeout.
module uart_tx_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 15,
  localparam int IDW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                   tx_clk,
  input  logic                   reset_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       ack,
  output logic [IDW-1:0]         gnt_id,
  output logic                   tx_start,
  output logic [WIDTH-1:0]       tx_data,
  input  logic                   tx_busy,
  output logic                   arb_busy,
  output logic                   err_timeout
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  // Reject configurations the transmitter interface cannot support.
  if (N_REQ < 2 || N_REQ > 8 || WIDTH != 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("uart_tx_arbiter: unsupported parameter set");
  end

  state_t           state_q, state_d;
  logic [IDW-1:0]   last_q, last_d;
  logic [IDW-1:0]   gnt_q, gnt_d;
  logic [WIDTH-1:0] data_q, data_d;

  logic [IDW-1:0]   winner;
  logic             found;

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             err_q, err_d;
`endif

  // Round-robin search: first pending request after the last grant, wrapping.
  always_comb begin
    int idx;
    idx    = 0;
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_q) + k) % N_REQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  // Next-state logic; the transmit byte only moves on the IDLE-to-ISSUE edge.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    data_d  = data_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
    err_d   = err_q;
    tmo_d   = '0;
`endif
    unique case (state_q)
      IDLE: begin
        // A still-busy transmitter blocks any new grant.
        if (found && !tx_busy) begin
          data_d  = req_data[int'(winner)*WIDTH +: WIDTH];
          gnt_d   = winner;
          last_d  = winner;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
`ifdef UART_TX_ARB_TIMEOUT_EN
        tmo_d = tmo_q + 1'b1;
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          // Transmitter never answered: drop the byte, flag it, move on.
          err_d   = 1'b1;
          state_d = IDLE;
        end
`else
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end
`endif
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and grant registers; last_q resets to N_REQ-1 so requester 0 wins first.
  always_ff @(posedge tx_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= IDW'(N_REQ - 1);
      gnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  // WAIT_BUSY cycle counter and sticky timeout flag.
  always_ff @(posedge tx_clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

  // Handshake outputs decode from state so they clear with the async reset.
  always_comb begin
    ack = '0;
    if (state_q == ISSUE) begin
      ack[gnt_q] = 1'b1;
    end
  end

  assign tx_start = (state_q == ISSUE);
  assign tx_data  = data_q;
  assign gnt_id   = gnt_q;
  assign arb_busy = (state_q != IDLE);

endmodule
